// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin bus arbiter.
// Includes the state encoding, requester count and circular-priority pick.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit searching circularly from last_ptr+1; last_ptr itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] last_ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = last_ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last_ptr + IDX_W'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_bus_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_bus_arbiter8_if;

    logic [arb_pkg::N_REQ-1:0] req;
    logic                      gnt_valid;
    logic [arb_pkg::IDX_W-1:0] gnt_idx;
    logic [arb_pkg::N_REQ-1:0] gnt_onehot;
    logic                      preempt;
    logic                      busy;

    modport slave (
        input  req,
        output gnt_valid, gnt_idx, gnt_onehot, preempt, busy
    );

    modport master (
        output req,
        input  gnt_valid, gnt_idx, gnt_onehot, preempt, busy
    );

endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 enable decoder: one-hot of i_in when i_en is high, all zero otherwise.
module decoder_3to8 (
    input  logic [2:0] i_in,
    input  logic       i_en,
    output logic [7:0] o_out
);

    assign o_out = i_en ? (8'b1 << i_in) : 8'b0;

endmodule

// File: rtl/rr_bus_arbiter8.sv
// Round-robin owner of one shared resource among 8 requesters, with grant hold,
// a mandatory turnaround gap and hold-timeout pre-emption when others are waiting.
module rr_bus_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    rr_bus_arbiter8_if.slave bus
);

    localparam logic [N_REQ-1:0] ONE      = 1;
    localparam logic [7:0]       HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] r_last_ptr;
    logic             r_gnt_valid;
    logic             r_preempt;
    logic [7:0]       r_hold_cnt;

    logic [N_REQ-1:0] w_others;
    logic             w_timeout;
    logic [N_REQ-1:0] w_onehot;

    assign w_others  = bus.req & ~(ONE << r_gnt_idx);
    assign w_timeout = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT) && (w_others != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_ptr  <= IDX_W'(N_REQ - 1);
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req != '0) begin
                        r_gnt_idx   <= rr_pick(bus.req, r_last_ptr);
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Release always goes through IDLE, which is the turnaround gap.
                    if (!bus.req[r_gnt_idx]) begin
                        r_last_ptr  <= r_gnt_idx;
                        r_gnt_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (w_timeout) begin
                        r_last_ptr  <= r_gnt_idx;
                        r_gnt_valid <= 1'b0;
                        r_preempt   <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    decoder_3to8 u_dec (
        .i_in  (r_gnt_idx),
        .i_en  (r_gnt_valid),
        .o_out (w_onehot)
    );

    assign bus.gnt_valid  = r_gnt_valid;
    assign bus.gnt_idx    = r_gnt_idx;
    assign bus.gnt_onehot = w_onehot;
    assign bus.preempt    = r_preempt;
    assign bus.busy       = r_gnt_valid;

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Self-checking bench for rr_bus_arbiter8 (MAX_HOLD=4) against a cycle-level
// behavioural model of the arbitration rules.
module tb_rr_bus_arbiter8;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    rr_bus_arbiter8_if bus ();

    rr_bus_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the bus, who released last, cycles owned so far.
    int m_owner;
    int m_last;
    int m_idx;
    int m_held;
    bit m_pre;

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 7;
        m_idx   = 0;
        m_held  = 0;
        m_pre   = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        logic [7:0] others;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 8; k++) begin
                if (r[(m_last + k) % 8]) begin
                    m_owner = (m_last + k) % 8;
                    m_idx   = m_owner;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (MH != 0 && m_held >= MH && others != 8'h00) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic logic [13:0] exp_vec();
        logic       v;
        logic [7:0] oh;
        v  = (m_owner >= 0);
        oh = v ? (8'h01 << m_idx) : 8'h00;
        return {v, 3'(m_idx), oh, m_pre, v};
    endfunction

    function automatic logic [13:0] got_vec();
        return {bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.preempt, bus.busy};
    endfunction

    task automatic step(input logic [7:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 8'hFF;
        @(negedge clk);
        model_reset();
        n_checks++;
        if (got_vec() !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h required=%h", got_vec(), 14'h0);
        end
        rst = 1'b0;
        bus.req = 8'h00;
    endtask

    task automatic test_single();
        apply_reset();
        step(8'h01);
        n_checks++;
        if (got_vec() !== exp_vec() || bus.gnt_onehot !== 8'h01) begin
            n_fail++;
            $display("FAIL single_grant got=%h required=%h", got_vec(), exp_vec());
        end
        step(8'h00);
        n_checks++;
        if (got_vec() !== exp_vec() || bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release got=%h required=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_rotation();
        logic [7:0] r;
        int order[$];
        int expd[$];
        logic prev_v;
        expd = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        apply_reset();
        prev_v = 1'b0;
        for (int c = 0; c < 25; c++) begin
            r = 8'hFF;
            if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
            step(r);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation_c%0d got=%h required=%h", c, got_vec(), exp_vec());
            end
            if (bus.gnt_valid === 1'b1 && prev_v === 1'b0) order.push_back(int'(bus.gnt_idx));
            prev_v = bus.gnt_valid;
        end
        n_checks++;
        if (order != expd) begin
            n_fail++;
            $display("FAIL rotation_order got=%p required=%p", order, expd);
        end
    endtask

    task automatic test_preempt();
        int order[$];
        int expd[$];
        int pre_cnt;
        logic prev_v;
        expd = '{3, 5, 3};
        apply_reset();
        pre_cnt = 0;
        prev_v  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(c == 0 ? 8'h08 : 8'h28);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL preempt_c%0d got=%h required=%h", c, got_vec(), exp_vec());
            end
            if (bus.preempt === 1'b1) pre_cnt++;
            if (bus.gnt_valid === 1'b1 && prev_v === 1'b0) order.push_back(int'(bus.gnt_idx));
            prev_v = bus.gnt_valid;
        end
        n_checks++;
        if (order != expd || pre_cnt != 2) begin
            n_fail++;
            $display("FAIL preempt_order got=%p/%0d required=%p/2", order, pre_cnt, expd);
        end
    endtask

    task automatic test_no_timeout();
        int bad;
        apply_reset();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step(8'h04);
            if (bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 3'd2 || bus.preempt !== 1'b0 ||
                got_vec() !== exp_vec()) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_timeout bad_cycles got=%0d required=0", bad);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(8'h40);
        step(8'h40);
        n_checks++;
        if (bus.gnt_idx !== 3'd6 || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre got=%h required=%h", got_vec(), exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt_onehot !== 8'h00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%h required=%h", got_vec(), 14'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(8'hC0);
        n_checks++;
        if (got_vec() !== exp_vec() || bus.gnt_idx !== 3'd6) begin
            n_fail++;
            $display("FAIL async_regrant got=%h required=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_release_race();
        apply_reset();
        step(8'h10);
        step(8'h02);
        n_checks++;
        if (got_vec() !== exp_vec() || bus.gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL race_gap got=%h required=%h", got_vec(), exp_vec());
        end
        step(8'h12);
        n_checks++;
        if (got_vec() !== exp_vec() || bus.gnt_idx !== 3'd1 || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL race_next got=%h required=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        int bad;
        apply_reset();
        r   = 8'h00;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++) begin
                if (r[b]) begin
                    if ($urandom_range(0, 5) == 0) r[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[b] = 1'b1;
                end
            end
            step(r);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_c%0d req=%h got=%h required=%h", c, r, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.req = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_no_timeout();
        test_async_reset();
        test_release_race();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
